// File: rtl/imem_loader_if.sv
// Byte-stream input and imem write port of the program loader.
interface imem_loader_if #(
  parameter int IW = 16,
  parameter int AW = 8
);
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          imem_we;
  logic [AW-1:0] imem_waddr;
  logic [IW-1:0] imem_wdata;

  modport master (
    output in_data, in_valid,
    input  in_ready, imem_we, imem_waddr, imem_wdata
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, imem_we, imem_waddr, imem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Parses a length-prefixed, checksummed byte frame into imem words; each write lands 1 cycle after
// its last byte, in_ready is high only while a frame is being consumed, and the CPU is held until a good load.
module imem_loader #(
  parameter int IW = 16,
  parameter int AW = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  imem_loader_if.slave bus,
  output logic         cpu_hold,
  output logic         done,
  output logic         err
);
  localparam int BPW = (IW + 7) / 8;
  localparam int BIW = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [16:0] CAP = 17'(1) << AW;

  typedef enum logic [2:0] {IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR} state_t;

  state_t           state_q, state_nxt;
  logic [7:0]       len_lo_q;
  logic [15:0]      len_q;
  logic [15:0]      word_cnt_q;
  logic [AW-1:0]    addr_q;
  logic [7:0]       csum_q;
  logic [BIW-1:0]   idx_q;
  logic [BPW*8-1:0] asm_q;
  logic [BPW*8-1:0] word_nxt;
  logic             we_q;
  logic [AW-1:0]    waddr_q;
  logic [IW-1:0]    wdata_q;

  logic        ready;
  logic        go;
  logic        take;
  logic        last_lane;
  logic        last_word;
  logic [15:0] len_full;

  assign len_full  = {bus.in_data, len_lo_q};
  assign last_lane = (idx_q == BIW'(BPW - 1));
  assign last_word = ((word_cnt_q + 16'd1) == len_q);
  assign take      = (state_q == DATA) && bus.in_valid;

  // Current byte dropped into its lane; earlier lanes of this word are already in asm_q.
  always_comb begin
    word_nxt = asm_q;
    for (int k = 0; k < BPW; k++) begin
      if (idx_q == BIW'(k)) word_nxt[k*8 +: 8] = bus.in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    ready     = 1'b0;
    go        = 1'b0;
    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          state_nxt = LEN_LO;
          go        = 1'b1;
        end
      end
      LEN_LO: begin
        ready = 1'b1;
        if (bus.in_valid) state_nxt = LEN_HI;
      end
      LEN_HI: begin
        ready = 1'b1;
        if (bus.in_valid) begin
          if (len_full == 16'd0)             state_nxt = CSUM;
          else if ({1'b0, len_full} > CAP)   state_nxt = ERR;
          else                               state_nxt = DATA;
        end
      end
      DATA: begin
        ready = 1'b1;
        if (bus.in_valid && last_lane && last_word) state_nxt = CSUM;
      end
      CSUM: begin
        ready = 1'b1;
        if (bus.in_valid) state_nxt = (bus.in_data == csum_q) ? DONE : ERR;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_lo_q   <= '0;
      len_q      <= '0;
      word_cnt_q <= '0;
      addr_q     <= '0;
      csum_q     <= '0;
      idx_q      <= '0;
      asm_q      <= '0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
    end else begin
      we_q <= 1'b0;
      if (go) begin
        word_cnt_q <= '0;
        addr_q     <= '0;
        csum_q     <= '0;
        idx_q      <= '0;
        asm_q      <= '0;
      end
      if (state_q == LEN_LO && bus.in_valid) len_lo_q <= bus.in_data;
      if (state_q == LEN_HI && bus.in_valid) len_q    <= len_full;
      if (take) begin
        csum_q <= csum_q + bus.in_data;
        asm_q  <= word_nxt;
        if (last_lane) begin
          idx_q      <= '0;
          we_q       <= 1'b1;
          waddr_q    <= addr_q;
          wdata_q    <= word_nxt[IW-1:0];
          addr_q     <= addr_q + AW'(1);
          word_cnt_q <= word_cnt_q + 16'd1;
        end else begin
          idx_q <= idx_q + BIW'(1);
        end
      end
    end
  end

  assign bus.in_ready   = ready;
  assign bus.imem_we    = we_q;
  assign bus.imem_waddr = waddr_q;
  assign bus.imem_wdata = wdata_q;
  assign done           = (state_q == DONE);
  assign err            = (state_q == ERR);
  assign cpu_hold       = (state_q != DONE);
endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed frames plus random frames, every output checked each cycle against a frame-position model.
module tb_imem_loader;
  localparam int IW  = 16;
  localparam int AW  = 8;
  localparam int BPW = 2;
  localparam int CAP = 256;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic start = 1'b0;
  logic cpu_hold, done, err;

  imem_loader_if #(.IW(IW), .AW(AW)) bus ();

  imem_loader #(.IW(IW), .AW(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bus      (bus),
    .cpu_hold (cpu_hold),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model state: 0 idle, 1 loading, 2 done, 3 error; position counts bytes accepted in the frame.
  int          m_status = 0;
  int          m_pos    = 0;
  int          m_n      = 0;
  int          mj       = 0;
  logic [7:0]  m_nlo    = 8'h00;
  logic [7:0]  m_sum    = 8'h00;
  logic [15:0] m_w      = 16'h0000;
  logic        m_we     = 1'b0;
  logic [7:0]  m_waddr  = 8'h00;
  logic [15:0] m_wdata  = 16'h0000;

  logic [7:0]  wl_addr[$];
  logic [15:0] wl_data[$];

  initial begin
    forever begin
      @(negedge clk);
      chk("in_ready",   bus.in_ready,   m_status == 1);
      chk("imem_we",    bus.imem_we,    m_we);
      chk("imem_waddr", bus.imem_waddr, m_waddr);
      chk("imem_wdata", bus.imem_wdata, m_wdata);
      chk("done",       done,           m_status == 2);
      chk("err",        err,            m_status == 3);
      chk("cpu_hold",   cpu_hold,       m_status != 2);
      if (bus.imem_we) begin
        wl_addr.push_back(bus.imem_waddr);
        wl_data.push_back(bus.imem_wdata);
      end
      m_we = 1'b0;
      if (rst) begin
        m_status = 0;
        m_pos    = 0;
        m_waddr  = 8'h00;
        m_wdata  = 16'h0000;
      end else if (start && m_status != 1) begin
        m_status = 1;
        m_pos    = 0;
        m_sum    = 8'h00;
        m_w      = 16'h0000;
      end else if (m_status == 1 && bus.in_valid) begin
        if (m_pos == 0) begin
          m_nlo = bus.in_data;
        end else if (m_pos == 1) begin
          m_n = {16'h0000, bus.in_data, m_nlo};
          if (m_n > CAP) m_status = 3;
        end else if (m_pos < 2 + BPW * m_n) begin
          mj = m_pos - 2;
          m_w[8*(mj % BPW) +: 8] = bus.in_data;
          m_sum = m_sum + bus.in_data;
          if (mj % BPW == BPW - 1) begin
            m_we    = 1'b1;
            m_waddr = 8'((mj / BPW) % CAP);
            m_wdata = m_w;
          end
        end else begin
          m_status = (bus.in_data == m_sum) ? 2 : 3;
        end
        m_pos++;
      end
    end
  end

  // mode 0: back-to-back, 1: in_valid low one cycle before every byte, 2: random gaps.
  task automatic send(input logic [7:0] fr[$], input int mode, input int start_at, input int rst_at);
    int g;
    int n;
    logic acc;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < fr.size(); i++) begin
      if (mode == 1)      g = 1;
      else if (mode == 2) g = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      else                g = 0;
      repeat (g) begin @(posedge clk); #1; end
      bus.in_valid = 1'b1;
      bus.in_data  = fr[i];
      if (i == start_at) start = 1'b1;
      acc = 1'b0;
      n   = 0;
      while (!acc && n < 64) begin
        acc = bus.in_ready;
        @(posedge clk); #1;
        n++;
      end
      bus.in_valid = 1'b0;
      start        = 1'b0;
      if (!acc) begin
        chk("handshake_timeout", 32'd0, 32'd1);
        break;
      end
      if (i == rst_at) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        break;
      end
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    wl_addr.delete();
    wl_data.delete();
  endtask

  task automatic chk_nominal_writes(input string tag);
    chk({tag, "_nwr"}, wl_addr.size(), 2);
    if (wl_addr.size() == 2) begin
      chk({tag, "_a0"}, wl_addr[0], 8'h00);
      chk({tag, "_d0"}, wl_data[0], 16'h1234);
      chk({tag, "_a1"}, wl_addr[1], 8'h01);
      chk({tag, "_d1"}, wl_data[1], 16'hABCD);
    end
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] nom[$];
    logic [7:0] fr[$];
    logic [7:0] sum;
    logic [7:0] b;
    int n;
    int r;
    bit good;

    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    nom = '{8'h02, 8'h00, 8'h34, 8'h12, 8'hCD, 8'hAB, 8'hBE};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", bus.in_ready, 1'b0);
    chk("rst_we",       bus.imem_we, 1'b0);
    chk("rst_waddr",    bus.imem_waddr, 8'h00);
    chk("rst_wdata",    bus.imem_wdata, 16'h0000);
    chk("rst_cpu_hold", cpu_hold, 1'b1);
    chk("rst_done",     done, 1'b0);
    chk("rst_err",      err, 1'b0);
    rst = 1'b0;
    @(posedge clk); #1;

    clear_log();
    send(nom, 0, -1, -1);
    chk_nominal_writes("nominal");
    chk("nominal_done", done, 1'b1);
    chk("nominal_err",  err, 1'b0);
    chk("nominal_hold", cpu_hold, 1'b0);

    fr = nom;
    fr[6] = 8'hBF;
    clear_log();
    send(fr, 0, -1, -1);
    chk_nominal_writes("badsum");
    chk("badsum_err",  err, 1'b1);
    chk("badsum_done", done, 1'b0);
    chk("badsum_hold", cpu_hold, 1'b1);

    clear_log();
    send('{8'h01, 8'h01}, 0, -1, -1);
    chk("oversize_nwr",   wl_addr.size(), 0);
    chk("oversize_err",   err, 1'b1);
    chk("oversize_ready", bus.in_ready, 1'b0);

    clear_log();
    send('{8'h00, 8'h00, 8'h00}, 0, -1, -1);
    chk("empty_nwr",  wl_addr.size(), 0);
    chk("empty_done", done, 1'b1);
    send('{8'h00, 8'h00, 8'h01}, 0, -1, -1);
    chk("empty_bad_err", err, 1'b1);

    clear_log();
    send(nom, 1, -1, -1);
    chk_nominal_writes("toggle");
    chk("toggle_done", done, 1'b1);

    clear_log();
    send(nom, 0, 3, -1);
    chk_nominal_writes("midstart");
    chk("midstart_done", done, 1'b1);

    clear_log();
    send(nom, 0, -1, 2);
    chk("rstmid_nwr",   wl_addr.size(), 0);
    chk("rstmid_ready", bus.in_ready, 1'b0);
    chk("rstmid_hold",  cpu_hold, 1'b1);
    chk("rstmid_waddr", bus.imem_waddr, 8'h00);
    chk("rstmid_wdata", bus.imem_wdata, 16'h0000);
    chk("rstmid_done",  done, 1'b0);
    clear_log();
    send(nom, 0, -1, -1);
    chk_nominal_writes("afterrst");
    chk("afterrst_done", done, 1'b1);

    for (int f = 0; f < 30; f++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      n = CAP;
      else if (r == 1) n = $urandom_range(257, 300);
      else             n = $urandom_range(0, 12);
      fr.delete();
      fr.push_back(n[7:0]);
      fr.push_back(n[15:8]);
      good = 1'b0;
      if (n <= CAP) begin
        sum = 8'h00;
        for (int k = 0; k < n * BPW; k++) begin
          b = 8'($urandom);
          fr.push_back(b);
          sum = sum + b;
        end
        good = ($urandom_range(0, 3) != 0);
        fr.push_back(good ? sum : sum + 8'h01);
      end
      clear_log();
      send(fr, 2, -1, -1);
      chk("rand_nwr",  wl_addr.size(), (n <= CAP) ? n : 0);
      chk("rand_done", done, good);
      chk("rand_err",  err, !good);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
